// File: rtl/bill_acceptor_if.sv
// Bill validator front end: debounces the throat sensor, classifies the
// denomination, and issues paced credit pulses plus stacker/eject commands.
module bill_acceptor_if #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLDOFF_CYCLES  = 3,
  parameter int JAM_CYCLES      = 64
) (
  input  logic       Clk,
  input  logic       RstN,
  input  logic       BillIn,
  input  logic [2:0] Denom,
  input  logic       Ready,
  input  logic       Bill,
  output logic       Ten,
  output logic       Twenty,
  output logic       Stack,
  output logic       Eject,
  output logic       Busy,
  output logic       Jam,
  output logic [7:0] AcceptCnt
);

  localparam int DW = 4;
  localparam int HW = $clog2(HOLDOFF_CYCLES + 1);
  localparam int JW = $clog2(JAM_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HO_LAST  = HW'(HOLDOFF_CYCLES - 1);
  localparam logic [JW-1:0] JAM_LAST = JW'(JAM_CYCLES - 1);

  localparam logic [2:0] CODE_TEN    = 3'd1;
  localparam logic [2:0] CODE_TWENTY = 3'd2;

  typedef enum logic [3:0] {
    ST_IDLE, ST_DEBOUNCE, ST_CLASSIFY, ST_CREDIT, ST_STACK,
    ST_EJECT, ST_HOLDOFF, ST_WAIT_CLEAR, ST_JAMMED
  } state_t;

  state_t        state_reg, state_next;
  logic [2:0]    denom_reg, denom_next;
  logic [DW-1:0] db_cnt_reg, db_cnt_next;
  logic [HW-1:0] hold_cnt_reg, hold_cnt_next;
  logic [JW-1:0] jam_cnt_reg, jam_cnt_next;
  logic          ten_reg, ten_next;
  logic          twenty_reg, twenty_next;
  logic          stack_reg, stack_next;
  logic          eject_reg, eject_next;
  logic          jam_reg, jam_next;
  logic [7:0]    accept_cnt_reg, accept_cnt_next;
  logic          denom_valid;

  assign denom_valid = (denom_reg == CODE_TEN) || (denom_reg == CODE_TWENTY);

  // Reset lands in WAIT_CLEAR so a bill held through reset is never credited.
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      state_reg      <= ST_WAIT_CLEAR;
      denom_reg      <= '0;
      db_cnt_reg     <= '0;
      hold_cnt_reg   <= '0;
      jam_cnt_reg    <= '0;
      ten_reg        <= 1'b0;
      twenty_reg     <= 1'b0;
      stack_reg      <= 1'b0;
      eject_reg      <= 1'b0;
      jam_reg        <= 1'b0;
      accept_cnt_reg <= '0;
    end else begin
      state_reg      <= state_next;
      denom_reg      <= denom_next;
      db_cnt_reg     <= db_cnt_next;
      hold_cnt_reg   <= hold_cnt_next;
      jam_cnt_reg    <= jam_cnt_next;
      ten_reg        <= ten_next;
      twenty_reg     <= twenty_next;
      stack_reg      <= stack_next;
      eject_reg      <= eject_next;
      jam_reg        <= jam_next;
      accept_cnt_reg <= accept_cnt_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    denom_next      = denom_reg;
    db_cnt_next     = db_cnt_reg;
    hold_cnt_next   = hold_cnt_reg;
    jam_cnt_next    = jam_cnt_reg;
    ten_next        = 1'b0;
    twenty_next     = 1'b0;
    stack_next      = 1'b0;
    eject_next      = 1'b0;
    jam_next        = jam_reg;
    accept_cnt_next = accept_cnt_reg;

    case (state_reg)
      ST_IDLE: begin
        if (BillIn) begin
          state_next  = ST_DEBOUNCE;
          denom_next  = Denom;
          db_cnt_next = DW'(1);
        end
      end
      ST_DEBOUNCE: begin
        if (!BillIn) begin
          state_next = ST_IDLE;
        end else if (Denom != denom_reg) begin
          denom_next  = Denom;
          db_cnt_next = DW'(1);
        end else if (db_cnt_reg == DB_LAST) begin
          state_next = ST_CLASSIFY;
        end else begin
          db_cnt_next = db_cnt_reg + DW'(1);
        end
      end
      // Outputs are registered, so each pulse is raised on entry to its state.
      ST_CLASSIFY: begin
        if (denom_valid && (Ready || Bill)) begin
          state_next  = ST_CREDIT;
          ten_next    = (denom_reg == CODE_TEN);
          twenty_next = (denom_reg == CODE_TWENTY);
          if (accept_cnt_reg != 8'hFF)
            accept_cnt_next = accept_cnt_reg + 8'd1;
        end else begin
          state_next = ST_EJECT;
          eject_next = 1'b1;
        end
      end
      ST_CREDIT: begin
        state_next = ST_STACK;
        stack_next = 1'b1;
      end
      ST_STACK: begin
        state_next    = ST_HOLDOFF;
        hold_cnt_next = '0;
      end
      ST_HOLDOFF: begin
        if (hold_cnt_reg == HO_LAST) begin
          state_next   = ST_WAIT_CLEAR;
          jam_cnt_next = '0;
        end else begin
          hold_cnt_next = hold_cnt_reg + HW'(1);
        end
      end
      ST_EJECT: begin
        state_next   = ST_WAIT_CLEAR;
        jam_cnt_next = '0;
      end
      ST_WAIT_CLEAR: begin
        if (!BillIn) begin
          state_next = ST_IDLE;
        end else if (jam_cnt_reg == JAM_LAST) begin
          state_next = ST_JAMMED;
          jam_next   = 1'b1;
        end else begin
          jam_cnt_next = jam_cnt_reg + JW'(1);
        end
      end
      ST_JAMMED: begin
        jam_next = 1'b1;
      end
      default: begin
        state_next = ST_WAIT_CLEAR;
      end
    endcase
  end

  assign Ten       = ten_reg;
  assign Twenty    = twenty_reg;
  assign Stack     = stack_reg;
  assign Eject     = eject_reg;
  assign Jam       = jam_reg;
  assign AcceptCnt = accept_cnt_reg;
  assign Busy      = (state_reg != ST_IDLE);

endmodule
